// File: rtl/packet_pkg.sv
// Shared packet types and helpers for the 4-port switch.
package packet_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned SRC_W     = 4;
  localparam int unsigned TGT_W     = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PKT_W     = SRC_W + TGT_W + DATA_W;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [TGT_W-1:0]  tgt;
    logic [DATA_W-1:0] data;
  } packet_t;

  // A packet is illegal when it targets nobody or names a non-existent source.
  function automatic logic is_illegal_packet(packet_t pkt);
    return (pkt.tgt == '0) || (32'(pkt.src) >= NUM_PORTS);
  endfunction

  // Port index idx steps after ptr in round-robin order.
  function automatic int unsigned rr_next(int unsigned ptr, int unsigned idx,
                                          int unsigned n = NUM_PORTS);
    return (ptr + idx) % n;
  endfunction

endpackage

// File: rtl/switch_arb_output.sv
// One crossbar output: registered internal valid/data pair plus egress cooldown counter.
module switch_arb_output
  import packet_pkg::*;
#(
  parameter int unsigned COOLDOWN = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    claim_en,
  input  packet_t claim_data,
  output logic    out_valid,
  output packet_t out_data,
  output logic    busy_c
);

  localparam int unsigned BUSY_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic [BUSY_W-1:0] busy_cnt;

  assign busy_c = (busy_cnt != '0);

  // Delivery register: valid pulses for one cycle, data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= claim_en;
      if (claim_en) begin
        out_data <= claim_data;
      end
    end
  end

  // Turnaround counter keeps the output out of the claim pool after each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (claim_en) begin
      busy_cnt <= BUSY_W'(COOLDOWN);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - BUSY_W'(1);
    end
  end

endmodule

// File: rtl/switch_arbiter.sv
// Round-robin greedy arbiter and crossbar: grants non-overlapping head requests, delivers one cycle later.
module switch_arbiter
  import packet_pkg::*;
#(
  parameter int unsigned NUM_PORTS = packet_pkg::NUM_PORTS,
  parameter int unsigned COOLDOWN  = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_target,
  input  packet_t [NUM_PORTS-1:0]             req_data,
  output logic [NUM_PORTS-1:0]                grant,
  output logic [NUM_PORTS-1:0]                out_valid,
  output packet_t [NUM_PORTS-1:0]             out_data,
  output logic [7:0]                          drop_count
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_PORTS + 1);

  logic [PTR_W-1:0]        rr_ptr;
  logic [NUM_PORTS-1:0]    busy;
  logic [NUM_PORTS-1:0]    grant_c;
  logic [NUM_PORTS-1:0]    claimed;
  logic [NUM_PORTS-1:0]    claim_en;
  packet_t [NUM_PORTS-1:0] claim_data;
  logic                    first_found;
  logic [PTR_W-1:0]        first_idx;
  logic [PTR_W-1:0]        scan_idx;
  logic [CNT_W-1:0]        drop_inc;
  logic [8:0]              drop_sum;
  logic [7:0]              drop_next;

  // Greedy scan from rr_ptr; a request wins only if its whole mask is free.
  always_comb begin
    grant_c     = '0;
    claimed     = '0;
    claim_en    = '0;
    claim_data  = '0;
    first_found = 1'b0;
    first_idx   = '0;
    scan_idx    = '0;
    drop_inc    = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      scan_idx = PTR_W'(rr_next(32'(rr_ptr), 32'(i), NUM_PORTS));
      if (req[scan_idx] && ((req_target[scan_idx] & (busy | claimed)) == '0)) begin
        grant_c[scan_idx] = 1'b1;
        claimed           = claimed | req_target[scan_idx];
        if (req_target[scan_idx] == '0) begin
          drop_inc = drop_inc + CNT_W'(1);
        end
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = scan_idx;
        end
        for (int o = 0; o < int'(NUM_PORTS); o++) begin
          if (req_target[scan_idx][o]) begin
            claim_en[o]   = 1'b1;
            claim_data[o] = req_data[scan_idx];
          end
        end
      end
    end
  end

  assign grant = grant_c & {NUM_PORTS{rst_n}};

  assign drop_sum  = {1'b0, drop_count} + 9'(drop_inc);
  assign drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

  // Pointer moves just past the first winner; idle cycles leave it in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (first_found) begin
      rr_ptr <= PTR_W'(rr_next(32'(first_idx), 32'd1, NUM_PORTS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_next;
    end
  end

  for (genvar o = 0; o < int'(NUM_PORTS); o++) begin : g_out
    switch_arb_output #(
      .COOLDOWN (COOLDOWN)
    ) u_out (
      .clk        (clk),
      .rst_n      (rst_n),
      .claim_en   (claim_en[o]),
      .claim_data (claim_data[o]),
      .out_valid  (out_valid[o]),
      .out_data   (out_data[o]),
      .busy_c     (busy[o])
    );
  end

endmodule

// File: tb/tb_switch_arbiter.sv
// Scoreboard bench for switch_arbiter: port FIFOs and arbitration modelled in the bench.
module tb_switch_arbiter;
  import packet_pkg::*;

  localparam int NP = 4;
  localparam int CD = 1;

  logic                 clk;
  logic                 rst_n;
  logic [NP-1:0]        req;
  logic [NP-1:0][NP-1:0] req_target;
  packet_t [NP-1:0]     req_data;
  logic [NP-1:0]        grant;
  logic [NP-1:0]        out_valid;
  packet_t [NP-1:0]     out_data;
  logic [7:0]           drop_count;

  switch_arbiter #(.NUM_PORTS(NP), .COOLDOWN(CD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_target (req_target),
    .req_data   (req_data),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tgt;
    logic [15:0] data;
  } pkt_req_t;

  typedef struct {
    logic [NP-1:0]       valid;
    logic [NP-1:0][15:0] data;
    logic [7:0]          drop;
  } sb_entry_t;

  pkt_req_t  pq0[$], pq1[$], pq2[$], pq3[$];
  sb_entry_t sb[$];

  int n_checks;
  int n_errors;
  int cyc;
  int rr_m;
  int drop_m;
  int last_g[NP];
  logic [NP-1:0][15:0] exp_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int q_size(input int p);
    case (p)
      0: return pq0.size();
      1: return pq1.size();
      2: return pq2.size();
      default: return pq3.size();
    endcase
  endfunction

  function automatic pkt_req_t q_head(input int p);
    case (p)
      0: return pq0[0];
      1: return pq1[0];
      2: return pq2[0];
      default: return pq3[0];
    endcase
  endfunction

  task automatic q_push(input int p, input logic [3:0] tgt, input logic [15:0] data);
    pkt_req_t e;
    e.tgt  = tgt;
    e.data = data;
    case (p)
      0: pq0.push_back(e);
      1: pq1.push_back(e);
      2: pq2.push_back(e);
      default: pq3.push_back(e);
    endcase
  endtask

  task automatic q_pop(input int p);
    pkt_req_t e;
    case (p)
      0: e = pq0.pop_front();
      1: e = pq1.pop_front();
      2: e = pq2.pop_front();
      default: e = pq3.pop_front();
    endcase
  endtask

  task automatic model_reset();
    sb_entry_t e;
    sb.delete();
    rr_m = 0;
    drop_m = 0;
    exp_data = '0;
    for (int o = 0; o < NP; o++) last_g[o] = -1000;
    e.valid = '0;
    e.data  = '0;
    e.drop  = '0;
    sb.push_back(e);
  endtask

  // One clock: present heads, check registered outputs and grants, predict next cycle.
  task automatic step();
    sb_entry_t e;
    sb_entry_t n;
    logic [NP-1:0] claimed;
    logic [NP-1:0] eg;
    pkt_req_t h;
    int first;
    int p;
    bit ok;
    for (int i = 0; i < NP; i++) begin
      if (q_size(i) > 0) begin
        h = q_head(i);
        req[i] = 1'b1;
        req_target[i] = h.tgt;
        req_data[i] = packet_t'(h.data);
      end else begin
        req[i] = 1'b0;
      end
    end
    @(negedge clk);
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val($sformatf("out_valid@%0d", cyc), {28'h0, out_valid}, {28'h0, e.valid});
      for (int o = 0; o < NP; o++)
        check_val($sformatf("out_data%0d@%0d", o, cyc), {16'h0, out_data[o]}, {16'h0, e.data[o]});
      check_val($sformatf("drop_count@%0d", cyc), {24'h0, drop_count}, {24'h0, e.drop});
    end
    claimed = '0;
    eg = '0;
    first = -1;
    n.valid = '0;
    n.data = exp_data;
    for (int i = 0; i < NP; i++) begin
      p = (rr_m + i) % NP;
      if (q_size(p) > 0) begin
        h = q_head(p);
        ok = ((h.tgt & claimed) == '0);
        for (int o = 0; o < NP; o++)
          if (h.tgt[o] && (cyc - last_g[o] <= CD)) ok = 1'b0;
        if (ok) begin
          eg[p] = 1'b1;
          claimed |= h.tgt;
          if (first < 0) first = p;
          if (h.tgt == 4'h0 && drop_m < 255) drop_m++;
          for (int o = 0; o < NP; o++) begin
            if (h.tgt[o]) begin
              n.valid[o] = 1'b1;
              n.data[o] = h.data;
              last_g[o] = cyc;
            end
          end
        end
      end
    end
    if (first >= 0) rr_m = (first + 1) % NP;
    check_val($sformatf("grant@%0d", cyc), {28'h0, grant}, {28'h0, eg});
    n.drop = 8'(drop_m);
    exp_data = n.data;
    sb.push_back(n);
    for (int i = 0; i < NP; i++) if (eg[i]) q_pop(i);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int extra);
    int budget;
    budget = 0;
    while ((q_size(0) + q_size(1) + q_size(2) + q_size(3)) > 0 && budget < 2000) begin
      step();
      budget++;
    end
    if (budget >= 2000) check_val("drain_timeout", 32'(budget), 32'd0);
    for (int i = 0; i < extra; i++) step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    req = '0;
    req_target = '0;
    req_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Grant must stay low while reset is held, even with requests present.
    req = 4'hF;
    req_target = {4'h1, 4'h2, 4'h4, 4'h8};
    #1;
    check_val("reset_grant", {28'h0, grant}, 32'h0);
    check_val("reset_valid", {28'h0, out_valid}, 32'h0);
    check_val("reset_drop", {24'h0, drop_count}, 32'h0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single unicast to output 2.
    q_push(0, 4'b0100, 16'h14A5);
    drain(3);

    // Contention for output 3.
    q_push(0, 4'b1000, 16'h0811);
    q_push(1, 4'b1000, 16'h1822);
    drain(3);

    // Parallel disjoint unicasts.
    q_push(0, 4'b0010, 16'h0233);
    q_push(2, 4'b0001, 16'h2144);
    drain(3);

    // Multicast blocked by an output busy from the previous grant.
    q_push(0, 4'b0100, 16'h0455);
    drain(0);
    q_push(1, 4'b0110, 16'h1666);
    drain(3);

    // Zero-mask drops saturate the counter.
    for (int i = 0; i < 65; i++)
      for (int p = 0; p < NP; p++) q_push(p, 4'b0000, 16'(i));
    drain(2);
    check_val("drop_saturated", {24'h0, drop_count}, 32'd255);

    // Random mixed traffic.
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++)
        if (q_size(p) < 4 && $urandom_range(0, 2) == 0)
          q_push(p, 4'($urandom_range(0, 15)), {4'(p), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))});
      step();
    end
    drain(3);

    // Reset in the cycle out_valid[3] is high.
    q_push(0, 4'b1000, 16'h08AA);
    q_push(1, 4'b1000, 16'h18BB);
    step();
    check_val("pre_reset_valid3", {31'h0, out_valid[3]}, 32'd1);
    rst_n = 1'b0;
    req = '0;
    #1;
    check_val("midrst_valid", {28'h0, out_valid}, 32'h0);
    check_val("midrst_data", {16'h0, out_data[3]}, 32'h0);
    check_val("midrst_grant", {28'h0, grant}, 32'h0);
    model_reset();
    q_push(2, 4'b1000, 16'h28CC);
    q_push(3, 4'b0100, 16'h34DD);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drain(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

Central arbiter and crossbar for the 4-port switch. It takes the head-of-FIFO requests from every switch port's ingress side and grants them in round-robin order. Each granted packet is delivered, one cycle later, on the internal valid/data pair of every port named in its target mask. Unicast and multicast requests are both supported, and the arbiter enforces the egress turnaround of each output port.

## Interface
Parameters:
- NUM_PORTS, 4: number of switch ports; target masks are NUM_PORTS bits wide.
- COOLDOWN, 1: cycles an output stays blocked for new grants after one is issued to it; matches the 2-cycle egress sequence.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NUM_PORTS  per-port request, high while that port's FIFO is non-empty.
- req_target  in  NUM_PORTS x 4  per-port destination mask; bit i selects port i.
- req_data  in  NUM_PORTS x 16  per-port packet {src[15:12], tgt[11:8], data[7:0]}.
- grant  out  NUM_PORTS  per-port one-cycle pop strobe, combinational in the request cycle.
- out_valid  out  NUM_PORTS  per-port internal_valid, registered.
- out_data  out  NUM_PORTS x 16  per-port internal_data, registered.
- drop_count  out  8  count of requests granted with an all-zero mask; saturates at 255.

## Operation
- Each cycle the arbiter scans requesters starting at rr_ptr, in order rr_ptr, rr_ptr+1, … mod NUM_PORTS.
- For each asserted req[p], it computes claim = req_target[p]. The request is accepted when claim has no overlap with the busy outputs or with outputs already claimed this cycle.
- Accepting a request sets grant[p] and adds claim to the claimed set. The scan then continues with the remaining requesters, which is a greedy matching.
- Several grants can be issued in one cycle when their masks do not overlap.
- A multicast request is granted atomically: all targeted outputs must be free at once. It is never partially delivered.
- A zero-mask request is always grantable. It consumes no outputs, produces no delivery, and increments drop_count.
- At the clock edge, for each output o claimed by requester p: out_valid[o] <= 1 and out_data[o] <= req_data[p].
- Unclaimed outputs: out_valid[o] <= 0 and out_data[o] holds its value.
- busy[o] is a down-counter. It loads COOLDOWN when o is claimed and decrements to 0 otherwise. Output o is free only when busy[o] == 0.
- rr_ptr updates only in cycles with at least one grant. It becomes (first granted index in scan order + 1) mod NUM_PORTS; otherwise it holds.
- A requester does not count its own source bit specially; self-addressed masks are delivered like any other.

## Timing
- Reset values:
  - grant combinationally 0 while rst_n is low.
  - out_valid = 0, out_data = 0, drop_count = 0.
  - busy[] = 0, rr_ptr = 0.
- Latency: grant in cycle g gives out_valid high in cycle g+1 for exactly one cycle.
- With COOLDOWN = 1, output o granted in cycle g is blocked in g+1 and grantable again in g+2, so the next out_valid[o] is at g+3. This matches egress IDLE->OUTPUT->IDLE.
- The arbiter never holds grant for a requester across cycles. The requesting port pops on the grant edge and presents its new head the next cycle.
- A req whose mask hits a busy output is simply not granted this cycle. It stays pending and is re-scanned next cycle without losing its place; rr_ptr does not advance past it unless another grant occurs.
- Simultaneous events: a grant and a busy reload to the same output cannot occur, since busy outputs are excluded from claims.
- drop_count saturation: a drop at 255 keeps the value at 255.
- Reset mid-operation clears all state immediately. Pending out_valid pulses are lost and the ports' FIFOs retain their entries.

## Structure
- packet_pkg gains:
  - NUM_PORTS constant.
  - packet_t packed struct {src, tgt, data}.
  - Function rr_next(ptr, idx).
- The existing is_illegal_packet stays in packet_pkg unchanged.
- One sub-module, switch_arb_output, instantiated per output. It contains the out_valid/out_data register and the busy counter, with inputs claim_en and claim_data.
- Scan, grant and rr_ptr logic live in the top.

## Test plan
- Single unicast: req[0]=1, target=4'b0100, data=16'h1_4_A5 -> grant[0] in cycle 0, out_valid[2]=1 with out_data[2]=16'h14A5 in cycle 1, all other out_valid 0.
- Contention: ports 0 and 1 both target 4'b1000 at rr_ptr=0 -> grant[0] first. Port 1 is granted 2 cycles later (cooldown). rr_ptr goes 1 then 2. Out_valid[3] pulses at cycles 1 and 3.
- Parallel: port0->4'b0010, port2->4'b0001 same cycle -> both granted in cycle 0, out_valid[1] and out_valid[0] both high in cycle 1.
- Multicast blocked: port1 mask 4'b0110 while output 2 is busy from a grant the previous cycle -> no grant that cycle. Grant next cycle, then out_valid[1] and out_valid[2] high together.
- Drop and saturation: 260 zero-mask grants -> no out_valid and drop_count=255.
- Reset mid-burst: assert rst_n low during a cycle with out_valid[3]=1 -> all outputs 0 immediately, rr_ptr=0, first post-reset grant goes to lowest-index requester.
